// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared state encoding, table word type and codec register table
// Contents: state_t (sequencer states), cfg_word_t ({7-bit reg, 9-bit data}), NUM_WORDS, CFG_TABLE
package codec_cfg_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR} state_t;
    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } cfg_word_t;
    localparam int NUM_WORDS = 10;
    localparam cfg_word_t [0:NUM_WORDS-1] CFG_TABLE = '{
        '{7'd15, 9'h000},
        '{7'd0,  9'h017},
        '{7'd1,  9'h017},
        '{7'd2,  9'h079},
        '{7'd3,  9'h079},
        '{7'd4,  9'h012},
        '{7'd5,  9'h000},
        '{7'd6,  9'h000},
        '{7'd7,  9'h042},
        '{7'd9,  9'h001}
    };
endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-bit tick generator
// Ports: clk (system clock), reset (sync, active high), clr (restart the count),
//        tick (one-cycle pulse every CLK_DIV cycles after the last restart)
module i2c_qtick #(
    parameter int CLK_DIV = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV + 1);
    logic [W-1:0] r_cnt;
    assign tick = r_cnt == W'(CLK_DIV - 1);
    always_ff @(posedge clk)
        if (reset || clr || tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: writes the codec register table over I2C after reset or on a start pulse
// Ports: clk, reset (sync, active high), start (rerun pulse, ignored while busy),
//        i2c_dat_in (sampled SDA for ACK), i2c_clk (SCL), i2c_dat (SDA drive, 1 = released),
//        busy, done (sticky), err (sticky, retries exhausted), word_idx (table word in flight)
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int          CLK_DIV   = 30,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int          MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       i2c_dat_in,
    output logic       i2c_clk,
    output logic       i2c_dat,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] word_idx
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    state_t          r_state;
    logic [1:0]      r_q;
    logic [1:0]      r_byte;
    logic [2:0]      r_bit;
    logic [RW-1:0]   r_retry;
    logic [3:0]      r_idx;
    logic            r_nack;
    logic            r_auto;
    logic            r_scl;
    logic            r_sda;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            w_tick;
    logic            w_clr;
    logic            w_qend;
    logic            w_bit;
    logic            w_scl;
    logic            w_sda;
    logic [23:0]     w_frame;
    cfg_word_t       w_word;

    // The divider is held cleared outside a sequence so START always opens on a full quarter;
    // every later state change lands on a tick, which restarts the count anyway.
    assign w_clr   = ~r_busy;
    assign w_qend  = w_tick && r_q == 2'd3;
    assign w_word  = CFG_TABLE[r_idx];
    assign w_frame = {DEV_ADDR, 1'b0, w_word.addr, w_word.data};
    assign w_bit   = w_frame[5'd23 - {r_byte, r_bit}];
    assign w_scl   = (r_state == S_BIT || r_state == S_ACK) ? r_q[1] :
                     (r_state == S_STOP) ? (r_q != 2'd0) : 1'b1;
    assign w_sda   = (r_state == S_START) ? ~r_q[1] :
                     (r_state == S_BIT) ? w_bit :
                     (r_state == S_STOP) ? r_q[1] : 1'b1;

    assign i2c_clk  = r_scl;
    assign i2c_dat  = r_sda;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign word_idx = r_idx;

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_byte  <= '0;
            r_bit   <= '0;
            r_retry <= '0;
            r_idx   <= '0;
            r_nack  <= 1'b0;
            r_auto  <= 1'b1;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_scl <= w_scl;
            r_sda <= w_sda;
            if (r_busy && w_tick) r_q <= r_q + 1'b1;
            if (r_state == S_ACK && r_q == 2'd2 && w_tick) r_nack <= i2c_dat_in;
            case (r_state)
                S_IDLE: if (start || r_auto) begin
                    r_auto  <= 1'b0;
                    r_state <= S_START;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_idx   <= '0;
                    r_retry <= '0;
                    r_q     <= '0;
                end
                S_START: if (w_qend) begin
                    r_state <= S_BIT;
                    r_bit   <= '0;
                    r_byte  <= '0;
                    r_nack  <= 1'b0;
                end
                S_BIT: if (w_qend) begin
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_state <= S_ACK;
                end
                S_ACK: if (w_qend) begin
                    if (r_nack || r_byte == 2'd2) r_state <= S_STOP;
                    else begin
                        r_state <= S_BIT;
                        r_byte  <= r_byte + 1'b1;
                    end
                end
                S_STOP: if (w_qend) begin
                    if (r_nack && r_retry == RW'(MAX_RETRY)) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (!r_nack && r_idx == 4'(NUM_WORDS - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_GAP;
                        r_retry <= r_nack ? r_retry + 1'b1 : '0;
                        r_idx   <= r_nack ? r_idx : r_idx + 1'b1;
                    end
                end
                S_GAP: if (w_qend) r_state <= S_START;
                S_DONE: r_state <= S_IDLE;
                S_ERR: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: bus-level self-checking bench for codec_cfg_seq with an I2C slave pad model
module tb_codec_cfg_seq;
    localparam int CLK_DIV = 4;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       i2c_dat_in;
    logic       i2c_clk;
    logic       i2c_dat;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] word_idx;
    logic       slave_low = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    logic [6:0] regs [10] = '{7'd15, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd9};
    logic [8:0] dats [10] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h000, 9'h042, 9'h001};

    int mode = 0;
    logic [31:0] cap_bits [$];
    int          cap_n [$];
    int          cap_idx [$];
    int  xmit, sda_bad, cond_bad, scl_bad, pulses;
    int  cyc = 0, t_rise = 0, nb = 0, m_idx = 0;
    bit  in_word = 0, rose = 0, hit = 0;
    logic [31:0] sr = '0;
    logic p_scl = 1'b1, p_sda = 1'b1;

    always #5 clk = ~clk;

    assign i2c_dat_in = i2c_dat & ~slave_low;

    codec_cfg_seq #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .i2c_dat_in (i2c_dat_in),
        .i2c_clk    (i2c_clk),
        .i2c_dat    (i2c_dat),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_idx   (word_idx)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] frame(input int w, input int n);
        logic [26:0] f;
        f = {8'h34, 1'b1, regs[w], dats[w][8], 1'b1, dats[w][7:0], 1'b1};
        return 32'(f >> (27 - n));
    endfunction

    // Bus decoder and slave: START/STOP by SDA edges with SCL high, bits on SCL rise,
    // ACK driven low after the SCL fall that follows bits 8, 17 and 26.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_word = 0;
            rose = 0;
            slave_low = 1'b0;
        end else begin
            if (i2c_clk && p_scl && i2c_dat != p_sda) begin
                hit = 1;
                if (!i2c_dat) begin
                    if (in_word) cond_bad++;
                    in_word = 1;
                    sr = '0;
                    nb = 0;
                    m_idx = int'(word_idx);
                end else begin
                    if (!in_word || nb == 0) cond_bad++;
                    else begin
                        cap_bits.push_back(sr >> 1);
                        cap_n.push_back(nb - 1);
                        cap_idx.push_back(m_idx);
                        xmit++;
                    end
                    in_word = 0;
                end
            end
            if (i2c_dat != p_sda && i2c_clk && !p_scl) sda_bad++;
            if (i2c_clk && !p_scl) begin
                rose = 1;
                hit = 0;
                t_rise = cyc;
                if (in_word) begin
                    sr = {sr[30:0], i2c_dat};
                    nb++;
                end
            end
            if (!i2c_clk && p_scl) begin
                if (rose && !hit) begin
                    pulses++;
                    if (cyc - t_rise != 2 * CLK_DIV) scl_bad++;
                end
                rose = 0;
                slave_low = in_word && (nb == 8 || nb == 17 || nb == 26) &&
                            (mode == 0 || (mode == 2 && !(xmit == 3 && nb == 17)));
            end
        end
        p_scl = i2c_clk;
        p_sda = i2c_dat;
    end

    task automatic clear_cap(input int md);
        cap_bits.delete();
        cap_n.delete();
        cap_idx.delete();
        mode = md;
        xmit = 0;
        sda_bad = 0;
        cond_bad = 0;
        scl_bad = 0;
        pulses = 0;
    endtask

    task automatic pulse_start();
        repeat ($urandom_range(2, 5)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err, 0);
        chk("start_busy", busy, 1);
        chk("start_idx0", word_idx, 0);
    endtask

    // Mode 0: slave always ACKs; 1: never ACKs; 2: NACKs byte 2 of word 3 once.
    task automatic run_check(input string nm, input int md);
        int ew [$];
        int en [$];
        int q_exp, bc;
        bit fin;
        if (md == 1) repeat (MAX_TRIES()) begin ew.push_back(0); en.push_back(9); end
        else for (int w = 0; w < 10; w++) begin
            if (md == 2 && w == 3) begin ew.push_back(3); en.push_back(18); end
            ew.push_back(w);
            en.push_back(27);
        end
        q_exp = 4 * (ew.size() - 1);
        foreach (en[i]) q_exp += 8 + 4 * en[i];
        bc = 0;
        fin = 0;
        for (int k = 0; k < 30000 && !fin; k++) begin
            if (busy) bc++;
            else if (bc > 0) fin = 1;
            if (!fin) begin
                start = busy && bc < 600 && $urandom_range(0, 99) == 0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({nm, "_finished"}, fin, 1);
        chk({nm, "_busy_cycles"}, bc, q_exp * CLK_DIV);
        chk({nm, "_done"}, done, md != 1);
        chk({nm, "_err"}, err, md == 1);
        chk({nm, "_n_xmit"}, cap_n.size(), ew.size());
        for (int i = 0; i < ew.size() && i < cap_n.size(); i++) begin
            chk($sformatf("%s_x%0d_bits", nm, i), cap_bits[i], frame(ew[i], en[i]));
            chk($sformatf("%s_x%0d_nbits", nm, i), cap_n[i], en[i]);
            chk($sformatf("%s_x%0d_idx", nm, i), cap_idx[i], ew[i]);
        end
        chk({nm, "_sda_while_scl_high"}, sda_bad, 0);
        chk({nm, "_start_stop_order"}, cond_bad, 0);
        chk({nm, "_scl_high_len"}, scl_bad, 0);
        chk({nm, "_scl_pulses_seen"}, pulses > 0, 1);
    endtask

    function automatic int MAX_TRIES();
        return 4;
    endfunction

    initial begin
        int wk;
        bit found;
        repeat (3) @(negedge clk);
        chk("rst_scl", i2c_clk, 1);
        chk("rst_sda", i2c_dat, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_idx", word_idx, 0);
        clear_cap(0);
        reset = 1'b0;
        @(negedge clk);
        chk("auto_start_busy", busy, 1);
        run_check("auto", 0);

        clear_cap(2);
        pulse_start();
        run_check("nack_w3", 2);

        clear_cap(1);
        pulse_start();
        run_check("nack_all", 1);

        clear_cap(0);
        pulse_start();
        wk = $urandom_range(0, 9);
        found = 0;
        for (int k = 0; k < 30000 && !found; k++) begin
            @(negedge clk);
            if (in_word && m_idx == wk && nb == 12 && !i2c_clk) found = 1;
        end
        chk("mid_reset_reached", found, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_scl", i2c_clk, 1);
        chk("mid_reset_sda", i2c_dat, 1);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_idx", word_idx, 0);
        repeat (2) @(negedge clk);
        clear_cap(0);
        reset = 1'b0;
        @(negedge clk);
        run_check("after_reset", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
